cpu_control_fsm: RTL
====================

// Module: cpu_control_fsm
// PURPOSE
// - Multicycle fetch/decode control stage directly upstream of the 16x16 register file and ALU.
// - Fetches a 16-bit instruction from BRAM and decodes it.
// - Drives regfile srcAddr/dstAddr/writeEn, ALU op, immediate, memory controls and the PC.
// - One instruction in flight; no pipelining, no branches.
// PARAMETERS
// - WIDTH     16  datapath/instruction width
// - REGBITS   4   register address width (16 registers)
// - RESET_PC  0   PC value loaded on reset
// PORTS
// - clk         in   1        system clock; all state updates on posedge
// - reset       in   1        synchronous, active-high; one clock; polarity/sync fixed
// - memData     in   WIDTH    BRAM read data, valid 1 cycle after address presented
// - pc          out  WIDTH    program counter
// - memAddrSel  out  1        0: mem addr = pc, 1: mem addr = regfile readData2 (mux in datapath)
// - memWe       out  1        BRAM write enable (store data = readData1)
// - srcAddr     out  REGBITS  regfile read-port-2 address = ir[3:0]
// - dstAddr     out  REGBITS  regfile read-port-1 / write address = ir[11:8]
// - regWriteEn  out  1        regfile write enable
// - wbSel       out  1        0: write ALU result, 1: write memData
// - aluOp       out  4        ALU function code
// - useImm      out  1        ALU B operand = immOut instead of readData2
// - immOut      out  WIDTH    sign-extended ir[7:0]
// BEHAVIOUR
// - Encoding: op=ir[15:12], Rdest=ir[11:8], ext=ir[7:4], Rsrc=ir[3:0].
//   - op 0000 R-type, by ext:
//     - 0101 ADD, 1001 SUB, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV: aluOp=ext, write back.
//     - 1011 CMP: aluOp=ext, no write back.
//   - op 0101 ADDI, 1001 SUBI, 1101 MOVI: aluOp=op, useImm=1, imm=sext(ir[7:0]).
//   - op 0100 ext 0000 LOAD Rdest,[Rsrc]; op 0100 ext 0100 STOR Rdest,[Rsrc].
//   - Anything else is a NOP: PC advances, no writes.
// - States:
//   - FETCH: memAddrSel=0 -> DECODE.
//   - DECODE: ir<=memData -> READ.
//   - READ: addresses stable; regfile latches operands -> EXEC.
//   - EXEC:
//     - ALU/imm: regWriteEn=1, wbSel=0, pc<=pc+1 -> FETCH.
//     - CMP/NOP: pc<=pc+1 -> FETCH.
//     - STOR: memAddrSel=1, memWe=1, pc<=pc+1 -> FETCH.
//     - LOAD: memAddrSel=1 -> LWB.
//   - LWB: regWriteEn=1, wbSel=1, pc<=pc+1 -> FETCH.
// - Latency: ALU/CMP/STOR/NOP 4 cycles; LOAD 5 cycles.
//   - A write completes before the next instruction's READ, so there are no RAW hazards and no forwarding.
// - regWriteEn and memWe: single-cycle pulses, Moore outputs decoded from state and ir.
// - srcAddr, dstAddr, aluOp, useImm and immOut are held from DECODE+1 until the next DECODE.
// - pc increments modulo 2^WIDTH: 16'hFFFF+1 -> 16'h0000.
// - Reset values:
//   - state=FETCH, pc=RESET_PC, ir=0.
//   - All enables 0; memAddrSel=0, wbSel=0, useImm=0, aluOp=0, immOut=0, src/dstAddr=0.
// - Reset in any state, including mid-EXEC/LWB:
//   - regWriteEn and memWe forced 0 in that same cycle.
//   - Next edge: FETCH with pc=RESET_PC. No partial write occurs.
// STRUCTURE
// - Shared package (cpu_defs): op/ext encoding constants, aluOp codes, state encoding, WIDTH/REGBITS defaults.
// - Sub-module instr_decoder: combinational ir -> {class, aluOp, useImm, immOut, writesReg}.
// - FSM, pc and ir registers stay in cpu_control_fsm.
// TESTING
// - Reset:
//   - reset=1 for 2 cycles -> pc=0, state FETCH, regWriteEn=memWe=0 throughout.
// - ADD R3,R4 (0x0354) at pc 0:
//   - dstAddr=3, srcAddr=4, aluOp=0101, useImm=0.
//   - regWriteEn high exactly in cycle 4 with wbSel=0; pc=1 after.
// - ADDI R2,#-3 (0x52FD):
//   - immOut=16'hFFFD, useImm=1, aluOp=0101; R2 written in cycle 4.
// - LOAD R1,[R6] (0x4106):
//   - memAddrSel=1 in EXEC; regWriteEn with wbSel=1 in cycle 5, dstAddr=1.
// - STOR R1,[R6] (0x4146):
//   - memWe pulse for 1 cycle, no regWriteEn.
// - CMP (0x03B4) and 0xF000:
//   - no regWriteEn, no memWe; pc+1 each.
// - Reset asserted during EXEC of ADD -> regWriteEn=0 that cycle, then FETCH at pc=0.
// - RESET_PC=16'hFFFF, NOP -> pc wraps to 0.

Source files
------------

// File: rtl/cpu_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm_pkg
// Shared definitions for the multicycle fetch/decode control stage:
//   - datapath / register-address width defaults
//   - instruction op / ext field encodings and ALU function codes
//   - FSM state encoding and decoded instruction classes
//   - immediate sign-extension helper
// -----------------------------------------------------------------------------
package cpu_control_fsm_pkg;

    localparam int CPU_WIDTH   = 16;
    localparam int CPU_REGBITS = 4;

    // Primary opcode field ir[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_MOVI  = 4'b1101;

    // Extended opcode field ir[7:4] for R-type and memory instructions
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    // ALU code driven when the instruction does not use the ALU
    localparam logic [3:0] ALU_IDLE = 4'b0000;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_READ   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_LWB    = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_CMP  = 3'd2,
        CLS_LOAD = 3'd3,
        CLS_STOR = 3'd4
    } instr_class_e;

    // Sign-extend the 8-bit immediate to the default datapath width
    function automatic logic [CPU_WIDTH-1:0] sext_imm8(input logic [7:0] imm);
        return {{(CPU_WIDTH-8){imm[7]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm_if
// Bus between the control stage and the datapath (BRAM, regfile, ALU).
//   master : control stage (drives pc, addresses, enables, ALU controls)
//   slave  : datapath (drives memData back)
// Signals:
//   memData    BRAM read data, valid one cycle after the address
//   pc         program counter
//   memAddrSel 0: BRAM addr = pc, 1: BRAM addr = regfile readData2
//   memWe      BRAM write enable (store data = readData1)
//   srcAddr    regfile read-port-2 address
//   dstAddr    regfile read-port-1 / write address
//   regWriteEn regfile write enable
//   wbSel      0: write ALU result, 1: write memData
//   aluOp      ALU function code
//   useImm     ALU B operand = immOut
//   immOut     sign-extended immediate
// -----------------------------------------------------------------------------
interface cpu_control_fsm_if #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
);
    logic [WIDTH-1:0]   memData;
    logic [WIDTH-1:0]   pc;
    logic               memAddrSel;
    logic               memWe;
    logic [REGBITS-1:0] srcAddr;
    logic [REGBITS-1:0] dstAddr;
    logic               regWriteEn;
    logic               wbSel;
    logic [3:0]         aluOp;
    logic               useImm;
    logic [WIDTH-1:0]   immOut;

    modport master (
        input  memData,
        output pc, memAddrSel, memWe, srcAddr, dstAddr,
        output regWriteEn, wbSel, aluOp, useImm, immOut
    );

    modport slave (
        output memData,
        input  pc, memAddrSel, memWe, srcAddr, dstAddr,
        input  regWriteEn, wbSel, aluOp, useImm, immOut
    );
endinterface

// File: rtl/cpu_control_fsm_instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational instruction decode.
// Ports:
//   ir_i         instruction word
//   cls_o        instruction class (ALU / CMP / LOAD / STOR / NOP)
//   alu_op_o     ALU function code
//   use_imm_o    ALU B operand comes from the immediate
//   imm_o        sign-extended ir[7:0]
//   writes_reg_o instruction writes the destination register via the ALU
// -----------------------------------------------------------------------------
module instr_decoder
    import cpu_control_fsm_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
) (
    input  logic [WIDTH-1:0] ir_i,
    output instr_class_e     cls_o,
    output logic [3:0]       alu_op_o,
    output logic             use_imm_o,
    output logic [WIDTH-1:0] imm_o,
    output logic             writes_reg_o
);

    logic [3:0] op_s;
    logic [3:0] ext_s;

    assign op_s  = ir_i[15:12];
    assign ext_s = ir_i[7:4];

    // Immediate is always presented; it only matters when use_imm_o is set
    assign imm_o = {{(WIDTH-8){ir_i[7]}}, ir_i[7:0]};

    // Classify the instruction and pick the ALU controls
    always_comb begin
        cls_o        = CLS_NOP;
        alu_op_o     = ALU_IDLE;
        use_imm_o    = 1'b0;
        writes_reg_o = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                case (ext_s)
                    EXT_ADD, EXT_SUB, EXT_AND, EXT_OR, EXT_XOR, EXT_MOV: begin
                        cls_o        = CLS_ALU;
                        alu_op_o     = ext_s;
                        writes_reg_o = 1'b1;
                    end
                    EXT_CMP: begin
                        cls_o    = CLS_CMP;
                        alu_op_o = ext_s;
                    end
                    default: begin
                        cls_o = CLS_NOP;
                    end
                endcase
            end
            OP_ADDI, OP_SUBI, OP_MOVI: begin
                cls_o        = CLS_ALU;
                alu_op_o     = op_s;
                use_imm_o    = 1'b1;
                writes_reg_o = 1'b1;
            end
            OP_MEM: begin
                case (ext_s)
                    EXT_LOAD: cls_o = CLS_LOAD;
                    EXT_STOR: cls_o = CLS_STOR;
                    default:  cls_o = CLS_NOP;
                endcase
            end
            default: begin
                cls_o = CLS_NOP;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
// Multicycle fetch/decode control stage in front of the register file and ALU.
// One instruction in flight: FETCH -> DECODE -> READ -> EXEC [-> LWB] -> FETCH.
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-high reset
//   bus    control-side (master) view of cpu_control_fsm_if
// Parameters:
//   WIDTH    datapath / instruction width
//   REGBITS  register address width
//   RESET_PC pc value loaded on reset
// -----------------------------------------------------------------------------
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
#(
    parameter int               WIDTH    = CPU_WIDTH,
    parameter int               REGBITS  = CPU_REGBITS,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_control_fsm_if.master     bus
);

    state_e             state_q;
    logic [WIDTH-1:0]   pc_q;
    logic [WIDTH-1:0]   ir_q;
    logic               mem_addr_sel_q;
    logic               mem_we_q;
    logic               reg_write_en_q;
    logic               wb_sel_q;
    logic [REGBITS-1:0] src_addr_q;
    logic [REGBITS-1:0] dst_addr_q;
    logic [3:0]         alu_op_q;
    logic               use_imm_q;
    logic [WIDTH-1:0]   imm_q;

    logic [WIDTH-1:0]   pc_d;
    logic [WIDTH-1:0]   dec_ir_s;
    instr_class_e       dec_cls_s;
    logic [3:0]         dec_alu_op_s;
    logic               dec_use_imm_s;
    logic [WIDTH-1:0]   dec_imm_s;
    logic               dec_writes_reg_s;

    // During DECODE the new instruction is still on memData; afterwards use ir
    always_comb begin
        if (state_q == ST_DECODE) begin
            dec_ir_s = bus.memData;
        end else begin
            dec_ir_s = ir_q;
        end
    end

    // Wrapping pc increment
    assign pc_d = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};

    instr_decoder #(
        .WIDTH (WIDTH)
    ) u_decoder (
        .ir_i         (dec_ir_s),
        .cls_o        (dec_cls_s),
        .alu_op_o     (dec_alu_op_s),
        .use_imm_o    (dec_use_imm_s),
        .imm_o        (dec_imm_s),
        .writes_reg_o (dec_writes_reg_s)
    );

    // Control FSM: outputs are registered for the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_FETCH;
            pc_q           <= RESET_PC;
            ir_q           <= {WIDTH{1'b0}};
            mem_addr_sel_q <= 1'b0;
            mem_we_q       <= 1'b0;
            reg_write_en_q <= 1'b0;
            wb_sel_q       <= 1'b0;
            src_addr_q     <= {REGBITS{1'b0}};
            dst_addr_q     <= {REGBITS{1'b0}};
            alu_op_q       <= 4'b0000;
            use_imm_q      <= 1'b0;
            imm_q          <= {WIDTH{1'b0}};
        end else begin
            // Write enables are single-cycle pulses unless re-armed below
            mem_we_q       <= 1'b0;
            reg_write_en_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    mem_addr_sel_q <= 1'b0;
                    state_q        <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir_q       <= bus.memData;
                    src_addr_q <= bus.memData[REGBITS-1:0];
                    dst_addr_q <= bus.memData[8 +: REGBITS];
                    alu_op_q   <= dec_alu_op_s;
                    use_imm_q  <= dec_use_imm_s;
                    imm_q      <= dec_imm_s;
                    state_q    <= ST_READ;
                end
                ST_READ: begin
                    // Arm the EXEC-cycle controls from the latched instruction
                    case (dec_cls_s)
                        CLS_ALU: begin
                            reg_write_en_q <= dec_writes_reg_s;
                            wb_sel_q       <= 1'b0;
                        end
                        CLS_STOR: begin
                            mem_addr_sel_q <= 1'b1;
                            mem_we_q       <= 1'b1;
                        end
                        CLS_LOAD: begin
                            mem_addr_sel_q <= 1'b1;
                        end
                        default: begin
                            mem_addr_sel_q <= 1'b0;
                        end
                    endcase
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec_cls_s == CLS_LOAD) begin
                        // Load data arrives next cycle; write it back in LWB
                        reg_write_en_q <= 1'b1;
                        wb_sel_q       <= 1'b1;
                        state_q        <= ST_LWB;
                    end else begin
                        pc_q           <= pc_d;
                        mem_addr_sel_q <= 1'b0;
                        wb_sel_q       <= 1'b0;
                        state_q        <= ST_FETCH;
                    end
                end
                ST_LWB: begin
                    pc_q           <= pc_d;
                    mem_addr_sel_q <= 1'b0;
                    wb_sel_q       <= 1'b0;
                    state_q        <= ST_FETCH;
                end
                default: begin
                    mem_addr_sel_q <= 1'b0;
                    wb_sel_q       <= 1'b0;
                    state_q        <= ST_FETCH;
                end
            endcase
        end
    end

    // Reset suppresses any armed write in the very cycle it is asserted
    assign bus.regWriteEn = reg_write_en_q & ~reset;
    assign bus.memWe      = mem_we_q & ~reset;

    assign bus.pc         = pc_q;
    assign bus.memAddrSel = mem_addr_sel_q;
    assign bus.wbSel      = wb_sel_q;
    assign bus.srcAddr    = src_addr_q;
    assign bus.dstAddr    = dst_addr_q;
    assign bus.aluOp      = alu_op_q;
    assign bus.useImm     = use_imm_q;
    assign bus.immOut     = imm_q;

endmodule
